// File: rtl/e1_mux_framer_pkg.sv
// Shared E1 framing constants and types, imported by both the mux framer and the demux side.
package e1_pkg;

  localparam logic [7:0] FAS_WORD  = 8'h9B;
  localparam logic [7:0] NFAS_WORD = 8'hDF;
  localparam logic [7:0] IDLE_WORD = 8'hFF;

  localparam int TS_PER_FRAME = 32;
  localparam int BITS_PER_TS  = 8;

  typedef logic [4:0] ts_t;

endpackage

// File: rtl/e1_mux_framer_tx_counter.sv
// Bit/timeslot/frame-parity counter for the transmit side; same structure as the demux lock counter.
module e1_tx_counter
  import e1_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] bit_cnt,
  output ts_t        ts_cnt,
  output logic       odd_frame,
  output logic       load,
  output logic       wrap
);

  assign load = en && (bit_cnt == 3'(BITS_PER_TS - 1));
  assign wrap = load && (ts_cnt == ts_t'(TS_PER_FRAME - 1));

  // bit_cnt and ts_cnt wrap naturally at their power-of-two widths
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bit_cnt   <= '0;
      ts_cnt    <= '0;
      odd_frame <= 1'b0;
    end else if (en) begin
      bit_cnt <= bit_cnt + 3'd1;
      if (load) ts_cnt <= ts_cnt + ts_t'(1);
      if (wrap) odd_frame <= ~odd_frame;
    end
  end

endmodule

// File: rtl/e1_mux_framer.sv
// E1 transmit framer: one-byte holding register, TS0 FAS/NFAS insertion and MSB-first serialiser.
module e1_mux_framer
  import e1_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sout,
  output logic       frame_start,
  output ts_t        ts_num,
  output logic       odd_frame,
  output logic       underrun
);

  logic [2:0] bit_cnt;
  ts_t        ts_cnt;
  logic       load;
  logic       wrap;
  logic [7:0] shift;
  logic [7:0] hold;
  logic       hold_full;
  logic       take;

  e1_tx_counter u_cnt (
    .clk       (clk),
    .clear     (clear),
    .en        (en),
    .bit_cnt   (bit_cnt),
    .ts_cnt    (ts_cnt),
    .odd_frame (odd_frame),
    .load      (load),
    .wrap      (wrap)
  );

  assign din_ready   = ~hold_full;
  assign take        = din_valid & din_ready;
  assign underrun    = load & ~wrap & ~hold_full;
  assign frame_start = (ts_cnt == '0) && (bit_cnt == '0);
  assign ts_num      = ts_cnt;
  assign sout        = shift[7];

  // At the frame wrap odd_frame still holds the old parity, so an even old frame means NFAS next
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shift <= FAS_WORD;
    end else if (load) begin
      if (wrap)           shift <= odd_frame ? FAS_WORD : NFAS_WORD;
      else if (hold_full) shift <= hold;
      else                shift <= IDLE_WORD;
    end else if (en) begin
      shift <= {shift[6:0], 1'b0};
    end
  end

  // take and a consuming load are exclusive: take needs hold_full low
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (take) begin
      hold      <= din;
      hold_full <= 1'b1;
    end else if (load && !wrap) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_e1_mux_framer.sv
// Self-checking bench for e1_mux_framer: directed vector table, corner-case sequences, randomized traffic vs a frame-position model.
module tb_e1_mux_framer;

  logic       clk;
  logic       clear;
  logic       en;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       frame_start;
  logic [4:0] ts_num;
  logic       odd_frame;
  logic       underrun;

  e1_mux_framer dut (
    .clk         (clk),
    .clear       (clear),
    .en          (en),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .sout        (sout),
    .frame_start (frame_start),
    .ts_num      (ts_num),
    .odd_frame   (odd_frame),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mp is the bit position inside a 512-bit FAS/NFAS pair, mcur the byte of the current slot,
  // mq the accepted-but-unsent bytes (at most one, since the framer buffers a single byte).
  int         mp;
  logic [7:0] mcur;
  logic [7:0] mq[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t pos=%0d)", nm, a, e, $time, mp);
    end
  endtask

  task automatic model_reset();
    mp   = 0;
    mcur = 8'h9B;
    mq.delete();
  endtask

  // Drive one cycle's inputs at the falling edge, compare against the model, then advance the model
  // to what the next rising edge should produce. Returns before that rising edge.
  task automatic step(input bit e, input bit v, input logic [7:0] d);
    int  b, ts, np, nts;
    bit  acc, x_und;
    @(negedge clk);
    en = e; din_valid = v; din = d;
    #1;
    b     = mp % 8;
    ts    = (mp / 8) % 32;
    x_und = e && (b == 7) && (((mp / 8 + 1) % 32) != 0) && (mq.size() == 0);
    chk("m_sout",        32'(sout),        32'(mcur[7-b]));
    chk("m_ts_num",      32'(ts_num),      32'(ts));
    chk("m_frame_start", 32'(frame_start), 32'(mp % 256 == 0));
    chk("m_odd_frame",   32'(odd_frame),   32'(mp >= 256));
    chk("m_din_ready",   32'(din_ready),   32'(mq.size() == 0));
    chk("m_underrun",    32'(underrun),    32'(x_und));
    acc = v && (mq.size() == 0);
    if (e) begin
      if (b == 7) begin
        np  = (mp + 1) % 512;
        nts = (np / 8) % 32;
        if (nts == 0)          mcur = (np >= 256) ? 8'hDF : 8'h9B;
        else if (mq.size() > 0) mcur = mq.pop_front();
        else                   mcur = 8'hFF;
        mp = np;
      end else begin
        mp = mp + 1;
      end
    end
    if (acc) mq.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; din_valid = 1'b0; clear = 1'b1;
    #1;
    chk("rst_sout",        32'(sout),        32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd1);
    chk("rst_ts_num",      32'(ts_num),      32'd0);
    chk("rst_odd_frame",   32'(odd_frame),   32'd0);
    chk("rst_din_ready",   32'(din_ready),   32'd1);
    chk("rst_underrun",    32'(underrun),    32'd0);
    en = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic rand_steps(input int n, input int en_pct);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 99) < en_pct, $urandom_range(0, 1) == 1, 8'($urandom));
  endtask

  typedef struct {
    bit         e;
    bit         v;
    logic [7:0] d;
    bit         x_sout;
    bit         x_rdy;
    bit         x_und;
    bit         x_fs;
    logic [4:0] x_ts;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [7:0] cap0, cap1;
    int         p, fs_cnt, und_cnt, en_cnt;
    logic       s_sout;
    logic [4:0] s_ts;

    clear = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0;
    model_reset();

    // After reset: TS0 = 9B, a byte A5 offered at cycle 2 goes out in TS1, TS1->TS2 load underruns.
    vt[0]  = '{1, 0, 8'h00, 1, 1, 0, 1, 5'd0};
    vt[1]  = '{1, 0, 8'h00, 0, 1, 0, 0, 5'd0};
    vt[2]  = '{1, 1, 8'hA5, 0, 1, 0, 0, 5'd0};
    vt[3]  = '{1, 0, 8'h00, 1, 0, 0, 0, 5'd0};
    vt[4]  = '{1, 0, 8'h00, 1, 0, 0, 0, 5'd0};
    vt[5]  = '{1, 0, 8'h00, 0, 0, 0, 0, 5'd0};
    vt[6]  = '{1, 0, 8'h00, 1, 0, 0, 0, 5'd0};
    vt[7]  = '{1, 0, 8'h00, 1, 0, 0, 0, 5'd0};
    vt[8]  = '{1, 0, 8'h00, 1, 1, 0, 0, 5'd1};
    vt[9]  = '{1, 0, 8'h00, 0, 1, 0, 0, 5'd1};
    vt[10] = '{1, 0, 8'h00, 1, 1, 0, 0, 5'd1};
    vt[11] = '{1, 0, 8'h00, 0, 1, 0, 0, 5'd1};
    vt[12] = '{1, 0, 8'h00, 0, 1, 0, 0, 5'd1};
    vt[13] = '{1, 0, 8'h00, 1, 1, 0, 0, 5'd1};
    vt[14] = '{1, 0, 8'h00, 0, 1, 0, 0, 5'd1};
    vt[15] = '{1, 0, 8'h00, 1, 1, 1, 0, 5'd1};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(vt[i].e, vt[i].v, vt[i].d);
      chk($sformatf("vec%0d_sout", i),  32'(sout),        32'(vt[i].x_sout));
      chk($sformatf("vec%0d_ready", i), 32'(din_ready),   32'(vt[i].x_rdy));
      chk($sformatf("vec%0d_und", i),   32'(underrun),    32'(vt[i].x_und));
      chk($sformatf("vec%0d_fs", i),    32'(frame_start), 32'(vt[i].x_fs));
      chk($sformatf("vec%0d_ts", i),    32'(ts_num),      32'(vt[i].x_ts));
    end

    // Reset mid-traffic, then the first byte must be FAS again.
    rand_steps(100, 100);
    do_reset();
    cap0 = '0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h00);
      cap0 = {cap0[6:0], sout};
    end
    chk("reset_first_byte", 32'(cap0), 32'h9B);

    // Frame alternation over 520 en-cycles with random payload.
    do_reset();
    fs_cnt = 0; cap0 = '0; cap1 = '0;
    for (int k = 0; k < 520; k++) begin
      step(1, $urandom_range(0, 1) == 1, 8'($urandom));
      if (frame_start) begin
        fs_cnt++;
        chk("fs_position", 32'(k % 256), 32'd0);
      end
      if (k >= 256 && k < 264) cap0 = {cap0[6:0], sout};
      if (k >= 512)            cap1 = {cap1[6:0], sout};
      if (k == 256) chk("odd_at_256", 32'(odd_frame), 32'd1);
      if (k == 512) chk("odd_at_512", 32'(odd_frame), 32'd0);
    end
    chk("fs_count",    32'(fs_cnt), 32'd3);
    chk("frame1_ts0",  32'(cap0),   32'hDF);
    chk("frame2_ts0",  32'(cap1),   32'h9B);

    // No writes for a whole frame: every payload load underruns, TS5 carries FF.
    do_reset();
    und_cnt = 0; cap0 = '0;
    for (int k = 0; k < 256; k++) begin
      p = mp;
      step(1, 0, 8'h00);
      if (underrun) und_cnt++;
      if (p == 38) chk("und_before_ts4_load", 32'(underrun), 32'd0);
      if (p == 39) chk("und_ts4_ts5_load",    32'(underrun), 32'd1);
      if (p >= 40 && p < 48) cap0 = {cap0[6:0], sout};
    end
    chk("und_count", 32'(und_cnt), 32'd31);
    chk("ts5_idle",  32'(cap0),    32'hFF);

    // Stall for 10 cycles in the middle of TS7; frame length in en-cycles stays 256.
    do_reset();
    en_cnt = 0;
    while (mp != 59) begin
      step(1, $urandom_range(0, 1) == 1, 8'($urandom));
      en_cnt++;
    end
    step(1, 0, 8'h00);
    en_cnt++;
    s_sout = sout; s_ts = ts_num;
    for (int k = 0; k < 10; k++) begin
      step(0, $urandom_range(0, 1) == 1, 8'($urandom));
      chk("stall_sout",   32'(sout),   32'(s_sout));
      chk("stall_ts_num", 32'(ts_num), 32'(s_ts));
    end
    while (en_cnt < 256) begin
      step(1, $urandom_range(0, 1) == 1, 8'($urandom));
      en_cnt++;
    end
    step(0, 0, 8'h00);
    chk("stall_frame_len_fs",  32'(frame_start), 32'd1);
    chk("stall_frame_len_odd", 32'(odd_frame),   32'd1);

    // Byte written in TS31 after its load point is held across TS0 and sent in TS1.
    do_reset();
    cap0 = '0; cap1 = '0;
    for (int k = 0; k < 272; k++) begin
      p = mp;
      step(1, p == 250, 8'h3C);
      if (p == 252) chk("hold_ts31_ready", 32'(din_ready), 32'd0);
      if (p >= 256 && p < 264) cap0 = {cap0[6:0], sout};
      if (p >= 264)            cap1 = {cap1[6:0], sout};
    end
    chk("hold_ts0_nfas", 32'(cap0), 32'hDF);
    chk("hold_ts1_data", 32'(cap1), 32'h3C);

    // Randomized traffic with stalls, a mid-run reset included.
    rand_steps(1500, 85);
    do_reset();
    rand_steps(1500, 90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/e1_mux_framer.md
# e1_mux_framer

Transmit-side E1 framer for the mux path. Accepts one parallel byte per payload timeslot (TS1–TS31) over a valid/ready handshake. Inserts the frame alignment word in TS0, alternating FAS and NFAS between even and odd frames. Serialises the 256-bit frame MSB-first onto a single line, which is the stream the demux-side bit/timeslot counter locks to.

## Interface
- FAS_WORD, 8'h9B, TS0 content in even frames (Si=1, then 0011011)
- NFAS_WORD, 8'hDF, TS0 content in odd frames (Si=1, bit2=1, A=0, Sa4–Sa8=1)
- IDLE_WORD, 8'hFF, byte sent in a payload timeslot when no data is held
- clk  in  1  bit clock; one serial bit per clk when en=1
- clear  in  1  asynchronous, active-high reset
- en  in  1  bit strobe; when low, all state holds
- din  in  8  payload byte
- din_valid  in  1  din is valid
- din_ready  out  1  holding register empty; transfer when din_valid & din_ready at posedge clk
- sout  out  1  serial E1 bit (shift register MSB)
- frame_start  out  1  high while bit 0 of TS0 is on sout
- ts_num  out  5  timeslot currently on sout
- odd_frame  out  1  0 = FAS frame, 1 = NFAS frame
- underrun  out  1  one-cycle pulse when IDLE_WORD is substituted

## Operation
- State:
  - bit_cnt 0..7
  - ts_cnt 0..31
  - odd_frame
  - shift[7:0]
  - hold[7:0] with hold_full
- Reset values:
  - bit_cnt=0, ts_cnt=0, odd_frame=0
  - shift=FAS_WORD, so sout=1
  - hold_full=0, din_ready=1
  - frame_start=1, ts_num=0, underrun=0
- Holding register:
  - din_ready = ~hold_full.
  - A transfer sets hold_full and captures din.
  - Independent of en.
- Shift with en=1 and bit_cnt<7: shift left by one (LSB filled with 0); bit_cnt+1.
- Load point, en=1 and bit_cnt==7: bit_cnt=0, and the next timeslot is nts=(ts_cnt+1) mod 32.
  - nts==0: toggle odd_frame. Load NFAS_WORD if the new frame is odd, otherwise FAS_WORD.
  - nts!=0, hold_full=1: shift=hold and hold_full clears. A din transfer in the same cycle is impossible because ready is low.
  - nts!=0, hold_full=0: shift=IDLE_WORD and underrun pulses for exactly this cycle.
- Decoded outputs:
  - frame_start = (ts_cnt==0 && bit_cnt==0), both frame parities.
  - ts_num = ts_cnt.
- en=0: counters, shift, odd_frame and underrun are frozen or low. The handshake still operates.
- Reset mid-frame: everything returns to reset values immediately. A byte held at that point is discarded. The next frame starts with FAS.

## Timing
- Continuous en: 8 cycles per timeslot, 256 cycles per frame, 512 cycles per FAS/NFAS pair.
- sout changes only on posedge clk after en=1. The first bit of a loaded byte appears the cycle after the load point.
- Byte latency: a byte accepted at any time before the load point of a payload slot is sent in that slot. The earliest is the load cycle itself if it was captured on a previous edge.
  - Capture and load on the same edge does not count; that byte waits for the next slot.
- din_ready rises the cycle after a load consumes the hold. The source therefore has 7 en-cycles to refill before the next slot.
- TS0 never consumes the hold. A byte held across TS0 goes out in TS1.
- underrun and frame_start are unregistered decodes of registered state, so they are glitch-free relative to clk.

## Structure
- Package e1_pkg holds:
  - FAS/NFAS/IDLE constants
  - TS_PER_FRAME=32, BITS_PER_TS=8
  - a ts_t (5-bit) typedef
- The demux side imports the same package.
- Sub-module e1_tx_counter holds bit_cnt, ts_cnt and odd_frame, with en, load-point and frame-wrap outputs. It mirrors the demux counter.
- The top level holds the shift register, holding register and load mux.

## Test plan
- Reset: assert clear mid-traffic with en=1 → sout=1, frame_start=1, ts_num=0, odd_frame=0, din_ready=1 immediately. The first 8 bits out are 1,0,0,1,1,0,1,1.
- Payload: write 8'hA5 during TS0 → TS1 bits are 1,0,1,0,0,1,0,1. din_ready returns to 1 one cycle after the load.
- Frame alternation: run 512 en-cycles → TS0 of frame 1 is 8'hDF with odd_frame=1. Frame 2 is 8'h9B, and frame_start pulses at cycles 0, 256 and 512.
- Underrun: no writes for TS5 → TS5 shifts 8'hFF and underrun pulses once at the TS4→TS5 load cycle.
- Stall: drop en for 10 cycles in the middle of TS7 → sout, ts_num and bit position are frozen. The remaining bits resume unchanged, and the frame length in en-cycles stays 256.
- Hold across TS0: write 8'h3C during TS31 after its load point → TS0 carries FAS/NFAS and TS1 carries 8'h3C.
